i2c_sht40_responder: RTL and testbench
======================================

# i2c_sht40_responder

I2C target that emulates an SHT40 humidity/temperature sensor, so the existing host-side SHT40 receive path can be exercised in simulation and on hardware loopback. It decodes the address and command bytes from the I2C master, waits a configurable measurement time, then returns the standard 6-byte frame: T_MSB, T_LSB, CRC, RH_MSB, RH_LSB, CRC. CRC is CRC-8 with polynomial 0x31 and init 0xFF, with no reflection and no final XOR.

## Interface
- DEV_ADDR, 7'h44: 7-bit target address.
- CMD_MEASURE, 8'hFD: high-precision measure command.
- CMD_SOFTRESET, 8'h94: soft reset command.
- MEAS_CYCLES, 1000: clk cycles from command ACK to data available. Range 1..2^20-1.
- clk  in  1  system clock. At least 16x the SCL frequency.
- rst  in  1  reset. Synchronous, active-high.
- scl_in  in  1  raw SCL; asynchronous.
- sda_in  in  1  raw SDA; asynchronous.
- sda_oe  out  1  1 = pull SDA low (open drain). 0 = release.
- Temp_Raw  in  16  temperature word, latched at measure-command ACK.
- RH_Raw  in  16  humidity word, latched at measure-command ACK.
- Cmd_Strobe  out  1  one-cycle pulse when any command byte is ACKed.
- Cmd_Byte  out  8  last ACKed command byte.
- Data_Ready  out  1  high when a measurement is available to read.
- Crc_Inject  in  1  corrupt the CRC bytes. Present only with SHT40_CRC_INJECT_EN.

## Operation
- scl_in and sda_in pass through a 2-flop synchronizer, then a previous-value register for edge detection.
- START: SDA falls while SCL is high. STOP: SDA rises while SCL is high.
- Bits are sampled on the SCL rising edge. sda_oe changes only on the SCL falling edge.
- States:
  - IDLE: wait for START.
  - ADDR: shift 8 bits in.
  - ADDR_ACK: ACK only when the address matches. Write bit selects CMD. Read bit selects TX_BYTE, and is ACKed only if Data_Ready=1.
  - CMD: shift 8 bits in.
  - CMD_ACK: always ACK the command byte.
  - TX_BYTE: shift 8 bits out, MSB first.
  - TX_ACK: sample the master's ACK/NACK.
  - WAIT_STOP: ignore the bus until STOP or START.
- Address mismatch or a read with Data_Ready=0: NACK (SDA released), go to WAIT_STOP.
- CMD_MEASURE, on ACK:
  - latch Temp_Raw and RH_Raw;
  - clear Data_Ready;
  - load the measurement counter with MEAS_CYCLES;
  - at 0, set Data_Ready.
- A new CMD_MEASURE while counting reloads the counter and re-latches the data.
- CMD_SOFTRESET: clear Data_Ready, stop the counter.
- Any other command: ACKed, pulses Cmd_Strobe, no other effect.
- Read frame:
  - byte index 0..5;
  - CRC bytes (index 2 and 5) are computed from the latched words at latch time;
  - index ≥6 transmits 0xFF (SDA released).
- Master ACK after a byte: continue with the next byte. Master NACK: go to WAIT_STOP.
- A completed read of all 6 bytes followed by NACK clears Data_Ready. A partial read leaves it set.
- START in any state (repeated start): go to ADDR and reset the bit counter and byte index.
- STOP in any state: go to IDLE with sda_oe=0.

## Timing
- Reset values:
  - sda_oe=0, Cmd_Strobe=0, Cmd_Byte=8'h00, Data_Ready=0;
  - state IDLE, counter 0, latched words 0.
- rst asserted mid-transfer releases SDA at the next clk edge.
- Edge-detect latency is 3 clk cycles from a pin change: 2 sync flops plus 1 edge register.
- sda_oe updates 1 cycle after SCL-fall detection. This holds SDA valid well before the next SCL rise, given the 16x clock ratio.
- The ACK bit is driven from the falling edge after bit 8 until the following falling edge.
- Cmd_Strobe and Cmd_Byte update in the same cycle as the SCL fall that begins the ACK bit.
- Data_Ready rises exactly MEAS_CYCLES clk cycles after Cmd_Strobe.

## Configuration
- Macro: SHT40_CRC_INJECT_EN.
- Defined:
  - the Crc_Inject port exists;
  - a read frame started while Crc_Inject=1 transmits both CRC bytes with bit 0 inverted.
  - This exercises the host's CRC_Error path.
- Undefined: the port is absent and CRC bytes are always correct.

## Structure
- Package sht40_pkg holds:
  - the state enum;
  - the CMD_MEASURE, CMD_SOFTRESET and DEV_ADDR defaults;
  - CRC_POLY=8'h31 and CRC_INIT=8'hFF;
  - FRAME_BYTES=6.
- Sub-module sht40_crc8: combinational, 16-bit word in, 8-bit CRC out. The unrolled 16-step shift/XOR lives here, and one instance is used per word.
- The top level holds the synchronizer, the bus FSM, the measurement counter and the frame mux.

## Test plan
- Write 0x88 + 0xFD, wait MEAS_CYCLES, read 0x89 with Temp_Raw=16'hBEEF, RH_Raw=16'h6666 → receive BE EF 92 66 66 followed by that word's CRC, address ACKed, Data_Ready then 0.
- Read 0x89 before MEAS_CYCLES elapses → address NACK, sda_oe stays 0, Data_Ready=0.
- Write to address 0x45 → NACK, no Cmd_Strobe, state returns to IDLE after STOP.
- Master NACKs after byte 2 → SDA released, STOP → IDLE, Data_Ready stays 1, and a re-read returns the full frame.
- Assert rst while driving bit 3 of byte 0 → sda_oe=0 next cycle, Data_Ready=0, the next transaction works.
- With SHT40_CRC_INJECT_EN and Crc_Inject=1, read the 0xBEEF frame → byte 2 = 0x93.

Source files
------------

// File: rtl/sht40_pkg.sv
// Shared types and constants for the SHT40 I2C responder.
// Latency: n/a (declarations and one pure function only).
// Backpressure: n/a.
package sht40_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_ADDR,
    ST_ADDR_ACK,
    ST_CMD,
    ST_CMD_ACK,
    ST_TX_BYTE,
    ST_TX_ACK,
    ST_WAIT_STOP
  } state_e;

  localparam logic [6:0]  DEV_ADDR_DEFAULT      = 7'h44;
  localparam logic [7:0]  CMD_MEASURE_DEFAULT   = 8'hFD;
  localparam logic [7:0]  CMD_SOFTRESET_DEFAULT = 8'h94;
  localparam int unsigned MEAS_CYCLES_DEFAULT   = 1000;

  localparam logic [7:0]  CRC_POLY    = 8'h31;
  localparam logic [7:0]  CRC_INIT    = 8'hFF;
  localparam int          FRAME_BYTES = 6;
  localparam logic [7:0]  FILL_BYTE   = 8'hFF;

  // Byte of the read frame at position idx; anything past the frame is idle-high fill.
  function automatic logic [7:0] frame_byte(input logic [2:0]  idx,
                                            input logic [15:0] t_word,
                                            input logic [15:0] rh_word,
                                            input logic [7:0]  t_crc,
                                            input logic [7:0]  rh_crc,
                                            input logic        inj);
    logic [7:0] b;
    case (idx)
      3'd0:    b = t_word[15:8];
      3'd1:    b = t_word[7:0];
      3'd2:    b = t_crc ^ {7'd0, inj};
      3'd3:    b = rh_word[15:8];
      3'd4:    b = rh_word[7:0];
      3'd5:    b = rh_crc ^ {7'd0, inj};
      default: b = FILL_BYTE;
    endcase
    return b;
  endfunction

endpackage

// File: rtl/sht40_crc8.sv
// CRC-8 (poly 0x31, init 0xFF, no reflection, no final XOR) over one 16-bit word.
// Latency: purely combinational.
// Backpressure: none.
module sht40_crc8
  import sht40_pkg::*;
(
  input  logic [15:0] data_in,
  output logic [7:0]  crc_out
);

  // Unrolled MSB-first shift/XOR, one step per data bit.
  always_comb begin : crc_calc
    logic [7:0] c;
    logic       fb;
    c = CRC_INIT;
    for (int i = 15; i >= 0; i--) begin
      fb = c[7] ^ data_in[i];
      c  = {c[6:0], 1'b0} ^ (fb ? CRC_POLY : 8'h00);
    end
    crc_out = c;
  end

endmodule

// File: rtl/i2c_sht40_responder.sv
// I2C target emulating an SHT40: address/command decode, timed measurement, 6-byte CRC'd read frame.
// Latency: 3 clk from pin change to edge detect; sda_oe moves 1 clk after SCL-fall detect; Data_Ready MEAS_CYCLES after Cmd_Strobe.
// Backpressure: reads before Data_Ready are NACKed; master NACK ends a read. Optional SHT40_CRC_INJECT_EN adds Crc_Inject.
module i2c_sht40_responder
  import sht40_pkg::*;
#(
  parameter logic [6:0]  DEV_ADDR      = DEV_ADDR_DEFAULT,
  parameter logic [7:0]  CMD_MEASURE   = CMD_MEASURE_DEFAULT,
  parameter logic [7:0]  CMD_SOFTRESET = CMD_SOFTRESET_DEFAULT,
  parameter int unsigned MEAS_CYCLES   = MEAS_CYCLES_DEFAULT
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        scl_in,
  input  logic        sda_in,
  output logic        sda_oe,
  input  logic [15:0] Temp_Raw,
  input  logic [15:0] RH_Raw,
`ifdef SHT40_CRC_INJECT_EN
  input  logic        Crc_Inject,
`endif
  output logic        Cmd_Strobe,
  output logic [7:0]  Cmd_Byte,
  output logic        Data_Ready
);

  localparam logic [19:0] MEAS_LOAD = 20'(MEAS_CYCLES);

  // Synchronizer and edge-detect history (reset to the idle-high bus level).
  logic scl_s1_q, scl_s2_q, scl_prev_q;
  logic sda_s1_q, sda_s2_q, sda_prev_q;

  state_e      state_q, state_d;
  logic [3:0]  bit_cnt_q, bit_cnt_d;
  logic [7:0]  shift_q, shift_d;
  logic [2:0]  byte_idx_q, byte_idx_d;
  logic        rw_q, rw_d;
  logic        mack_q, mack_d;
  logic        inj_q, inj_d;
  logic        sda_oe_q, sda_oe_d;
  logic        cmd_strobe_q, cmd_strobe_d;
  logic [7:0]  cmd_byte_q, cmd_byte_d;
  logic        data_ready_q, data_ready_d;
  logic [19:0] meas_cnt_q, meas_cnt_d;
  logic [15:0] temp_q, temp_d;
  logic [15:0] rh_q, rh_d;
  logic [7:0]  crc_t_q, crc_t_d;
  logic [7:0]  crc_rh_q, crc_rh_d;

  logic       scl_rise, scl_fall, start_det, stop_det;
  logic       read_done;
  logic       inj_in;
  logic [7:0] crc_t_in, crc_rh_in;
  logic [7:0] cur_byte, nxt_byte;
  logic [2:0] nxt_idx, tx_bit_sel;

`ifdef SHT40_CRC_INJECT_EN
  assign inj_in = Crc_Inject;
`else
  assign inj_in = 1'b0;
`endif

  sht40_crc8 u_crc_t  (.data_in(Temp_Raw), .crc_out(crc_t_in));
  sht40_crc8 u_crc_rh (.data_in(RH_Raw),   .crc_out(crc_rh_in));

  assign scl_rise  =  scl_s2_q & ~scl_prev_q;
  assign scl_fall  = ~scl_s2_q &  scl_prev_q;
  assign start_det =  scl_s2_q &  scl_prev_q & ~sda_s2_q &  sda_prev_q;
  assign stop_det  =  scl_s2_q &  scl_prev_q &  sda_s2_q & ~sda_prev_q;

  assign nxt_idx    = (byte_idx_q == 3'd6) ? 3'd6 : byte_idx_q + 3'd1;
  assign tx_bit_sel = 3'd7 - bit_cnt_q[2:0];
  assign cur_byte   = frame_byte(byte_idx_q, temp_q, rh_q, crc_t_q, crc_rh_q, inj_q);
  assign nxt_byte   = frame_byte(nxt_idx,    temp_q, rh_q, crc_t_q, crc_rh_q, inj_q);

  // Bus FSM: START/STOP override everything, otherwise bit shifting and ACK handling per state.
  always_comb begin
    state_d      = state_q;
    bit_cnt_d    = bit_cnt_q;
    shift_d      = shift_q;
    byte_idx_d   = byte_idx_q;
    rw_d         = rw_q;
    mack_d       = mack_q;
    inj_d        = inj_q;
    sda_oe_d     = sda_oe_q;
    cmd_strobe_d = 1'b0;
    cmd_byte_d   = cmd_byte_q;
    read_done    = 1'b0;
    if (stop_det) begin
      state_d   = ST_IDLE;
      sda_oe_d  = 1'b0;
      bit_cnt_d = 4'd0;
    end else if (start_det) begin
      state_d    = ST_ADDR;
      sda_oe_d   = 1'b0;
      bit_cnt_d  = 4'd0;
      byte_idx_d = 3'd0;
    end else begin
      case (state_q)
        ST_ADDR, ST_CMD: begin
          if (scl_rise) begin
            shift_d   = {shift_q[6:0], sda_s2_q};
            bit_cnt_d = bit_cnt_q + 4'd1;
          end else if (scl_fall && bit_cnt_q == 4'd8) begin
            bit_cnt_d = 4'd0;
            if (state_q == ST_ADDR) begin
              if (shift_q[7:1] == DEV_ADDR && (!shift_q[0] || data_ready_q)) begin
                state_d  = ST_ADDR_ACK;
                sda_oe_d = 1'b1;
                rw_d     = shift_q[0];
                if (shift_q[0]) inj_d = inj_in;
              end else begin
                state_d  = ST_WAIT_STOP;
                sda_oe_d = 1'b0;
              end
            end else begin
              state_d      = ST_CMD_ACK;
              sda_oe_d     = 1'b1;
              cmd_strobe_d = 1'b1;
              cmd_byte_d   = shift_q;
            end
          end
        end
        ST_ADDR_ACK: begin
          if (scl_fall) begin
            bit_cnt_d = 4'd0;
            if (rw_q) begin
              state_d    = ST_TX_BYTE;
              byte_idx_d = 3'd0;
              sda_oe_d   = ~temp_q[15];
            end else begin
              state_d  = ST_CMD;
              sda_oe_d = 1'b0;
            end
          end
        end
        ST_CMD_ACK: begin
          if (scl_fall) begin
            state_d  = ST_WAIT_STOP;
            sda_oe_d = 1'b0;
          end
        end
        ST_TX_BYTE: begin
          if (scl_rise) begin
            bit_cnt_d = bit_cnt_q + 4'd1;
          end else if (scl_fall) begin
            if (bit_cnt_q == 4'd8) begin
              state_d   = ST_TX_ACK;
              sda_oe_d  = 1'b0;
              bit_cnt_d = 4'd0;
            end else begin
              sda_oe_d = ~cur_byte[tx_bit_sel];
            end
          end
        end
        ST_TX_ACK: begin
          if (scl_rise) begin
            mack_d = ~sda_s2_q;
          end else if (scl_fall) begin
            if (mack_q) begin
              state_d    = ST_TX_BYTE;
              byte_idx_d = nxt_idx;
              sda_oe_d   = ~nxt_byte[7];
            end else begin
              state_d   = ST_WAIT_STOP;
              sda_oe_d  = 1'b0;
              read_done = (byte_idx_q >= 3'(FRAME_BYTES - 1));
            end
          end
        end
        ST_IDLE, ST_WAIT_STOP: ;
        default: state_d = ST_IDLE;
      endcase
    end
  end

  // Measurement timer, data latch and Data_Ready bookkeeping driven by accepted commands.
  always_comb begin
    meas_cnt_d   = meas_cnt_q;
    data_ready_d = data_ready_q;
    temp_d       = temp_q;
    rh_d         = rh_q;
    crc_t_d      = crc_t_q;
    crc_rh_d     = crc_rh_q;
    if (meas_cnt_q != 20'd0) begin
      meas_cnt_d = meas_cnt_q - 20'd1;
      if (meas_cnt_q == 20'd1) data_ready_d = 1'b1;
    end
    if (read_done) data_ready_d = 1'b0;
    if (cmd_strobe_d) begin
      if (cmd_byte_d == CMD_MEASURE) begin
        temp_d       = Temp_Raw;
        rh_d         = RH_Raw;
        crc_t_d      = crc_t_in;
        crc_rh_d     = crc_rh_in;
        meas_cnt_d   = MEAS_LOAD;
        data_ready_d = 1'b0;
      end else if (cmd_byte_d == CMD_SOFTRESET) begin
        meas_cnt_d   = 20'd0;
        data_ready_d = 1'b0;
      end
    end
  end

  // All state registers, synchronous active-high reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      scl_s1_q     <= 1'b1;
      scl_s2_q     <= 1'b1;
      scl_prev_q   <= 1'b1;
      sda_s1_q     <= 1'b1;
      sda_s2_q     <= 1'b1;
      sda_prev_q   <= 1'b1;
      state_q      <= ST_IDLE;
      bit_cnt_q    <= 4'd0;
      shift_q      <= 8'd0;
      byte_idx_q   <= 3'd0;
      rw_q         <= 1'b0;
      mack_q       <= 1'b0;
      inj_q        <= 1'b0;
      sda_oe_q     <= 1'b0;
      cmd_strobe_q <= 1'b0;
      cmd_byte_q   <= 8'h00;
      data_ready_q <= 1'b0;
      meas_cnt_q   <= 20'd0;
      temp_q       <= 16'd0;
      rh_q         <= 16'd0;
      crc_t_q      <= 8'd0;
      crc_rh_q     <= 8'd0;
    end else begin
      scl_s1_q     <= scl_in;
      scl_s2_q     <= scl_s1_q;
      scl_prev_q   <= scl_s2_q;
      sda_s1_q     <= sda_in;
      sda_s2_q     <= sda_s1_q;
      sda_prev_q   <= sda_s2_q;
      state_q      <= state_d;
      bit_cnt_q    <= bit_cnt_d;
      shift_q      <= shift_d;
      byte_idx_q   <= byte_idx_d;
      rw_q         <= rw_d;
      mack_q       <= mack_d;
      inj_q        <= inj_d;
      sda_oe_q     <= sda_oe_d;
      cmd_strobe_q <= cmd_strobe_d;
      cmd_byte_q   <= cmd_byte_d;
      data_ready_q <= data_ready_d;
      meas_cnt_q   <= meas_cnt_d;
      temp_q       <= temp_d;
      rh_q         <= rh_d;
      crc_t_q      <= crc_t_d;
      crc_rh_q     <= crc_rh_d;
    end
  end

  assign sda_oe     = sda_oe_q;
  assign Cmd_Strobe = cmd_strobe_q;
  assign Cmd_Byte   = cmd_byte_q;
  assign Data_Ready = data_ready_q;

endmodule

// File: tb/tb_i2c_sht40_responder.sv
// Bench for i2c_sht40_responder: bit-banged I2C master, reference model of the sensor, queue scoreboard.
// Latency: n/a.
// Backpressure: n/a. Define SHT40_CRC_INJECT_EN to also exercise CRC corruption.
`timescale 1ns/1ps
module tb_i2c_sht40_responder;
  import sht40_pkg::*;

  localparam int MEAS = 600;
  localparam int Q    = 60;   // quarter SCL period; SCL period = 24 clk

  logic        clk = 1'b0;
  logic        rst;
  logic        scl_m, sda_m;
  logic        sda_bus;
  logic        sda_oe, Cmd_Strobe, Data_Ready;
  logic [7:0]  Cmd_Byte;
  logic [15:0] Temp_Raw, RH_Raw;
`ifdef SHT40_CRC_INJECT_EN
  logic        Crc_Inject;
`endif

  assign sda_bus = sda_m & ~sda_oe;
  always #5 clk = ~clk;

  i2c_sht40_responder #(.MEAS_CYCLES(MEAS)) dut (
    .clk(clk), .rst(rst), .scl_in(scl_m), .sda_in(sda_bus), .sda_oe(sda_oe),
    .Temp_Raw(Temp_Raw), .RH_Raw(RH_Raw),
`ifdef SHT40_CRC_INJECT_EN
    .Crc_Inject(Crc_Inject),
`endif
    .Cmd_Strobe(Cmd_Strobe), .Cmd_Byte(Cmd_Byte), .Data_Ready(Data_Ready)
  );

  // ---------------- scoreboard ----------------
  typedef struct { string name; int val; } exp_t;
  exp_t exp_q[$];
  int   obs_q[$];
  int   exp_cmd_q[$];
  int   n_pass = 0, n_total = 0;
  int   cyc = 0, strobe_cyc = 0, oe_cnt = 0;

  always @(posedge clk) begin
    cyc++;
    if (sda_oe) oe_cnt++;
  end

  // Monitor: compares command strobes and queued observations against expectations.
  always @(negedge clk) begin
    exp_t e;
    int   a, ec;
    if (Cmd_Strobe) begin
      strobe_cyc = cyc;
      n_total++;
      if (exp_cmd_q.size() == 0) begin
        $display("FAIL cmd_strobe: unexpected strobe with Cmd_Byte=%02h, expected no strobe", Cmd_Byte);
      end else begin
        ec = exp_cmd_q.pop_front();
        if (int'(Cmd_Byte) == ec) n_pass++;
        else $display("FAIL cmd_byte: got %02h, expected %02h", Cmd_Byte, ec);
      end
    end
    if (obs_q.size() > 0) begin
      a = obs_q.pop_front();
      n_total++;
      if (exp_q.size() == 0) begin
        $display("FAIL orphan_obs: got %0h, expected nothing", a);
      end else begin
        e = exp_q.pop_front();
        if (a == e.val) n_pass++;
        else $display("FAIL %s: got %0h, expected %0h", e.name, a, e.val);
      end
    end
  end

  task automatic push_exp(input string name, input int val);
    exp_t e;
    e.name = name;
    e.val  = val;
    exp_q.push_back(e);
  endtask

  task automatic sb_check(input string name, input int act, input int expv);
    push_exp(name, expv);
    obs_q.push_back(act);
  endtask

  // ---------------- reference model ----------------
  logic [15:0] m_t = 16'd0, m_rh = 16'd0;
  bit          m_dr = 1'b0;
  bit          m_inj = 1'b0;

  function automatic logic [7:0] ref_crc(input logic [15:0] w);
    logic [7:0] c;
    logic [7:0] b;
    c = 8'hFF;
    for (int k = 0; k < 2; k++) begin
      b = (k == 0) ? w[15:8] : w[7:0];
      c = c ^ b;
      for (int j = 0; j < 8; j++) c = c[7] ? ((c << 1) ^ 8'h31) : (c << 1);
    end
    return c;
  endfunction

  function automatic int ref_byte(input int idx);
    logic [7:0] fr [6];
    fr[0] = m_t[15:8];
    fr[1] = m_t[7:0];
    fr[2] = ref_crc(m_t) ^ {7'd0, m_inj};
    fr[3] = m_rh[15:8];
    fr[4] = m_rh[7:0];
    fr[5] = ref_crc(m_rh) ^ {7'd0, m_inj};
    return (idx < 6) ? int'(fr[idx]) : 32'hFF;
  endfunction

  // ---------------- I2C master ----------------
  task automatic bus_start();
    sda_m = 1'b1; #Q; scl_m = 1'b1; #Q; sda_m = 1'b0; #Q; scl_m = 1'b0; #Q;
  endtask

  task automatic bus_stop();
    sda_m = 1'b0; #Q; scl_m = 1'b1; #Q; sda_m = 1'b1; #Q;
  endtask

  task automatic write_bit(input logic b);
    sda_m = b; #Q; scl_m = 1'b1; #(2*Q); scl_m = 1'b0; #Q;
  endtask

  task automatic read_bit(output logic b);
    sda_m = 1'b1; #Q; scl_m = 1'b1; #Q; b = sda_bus; #Q; scl_m = 1'b0; #Q;
  endtask

  task automatic write_byte(input logic [7:0] d, output logic ack);
    logic b;
    for (int i = 7; i >= 0; i--) write_bit(d[i]);
    read_bit(b);
    ack = ~b;
  endtask

  task automatic read_byte(input logic ack, output logic [7:0] d);
    logic b;
    for (int i = 7; i >= 0; i--) begin
      read_bit(b);
      d[i] = b;
    end
    write_bit(~ack);
  endtask

  task automatic i2c_write(input logic [7:0] ab, input logic [7:0] cmd, input bit exp_ack, input string tag);
    logic ack;
    bus_start();
    write_byte(ab, ack);
    sb_check({tag, "_addr_ack"}, int'(ack), int'(exp_ack));
    if (ack) begin
      write_byte(cmd, ack);
      sb_check({tag, "_cmd_ack"}, int'(ack), 1);
    end
    bus_stop();
  endtask

  task automatic i2c_read(input int nbytes, input bit exp_ack, input string tag);
    logic       ack;
    logic [7:0] d;
    bus_start();
    write_byte(8'h89, ack);
    sb_check({tag, "_addr_ack"}, int'(ack), int'(exp_ack));
    if (ack) begin
      for (int i = 0; i < nbytes; i++) begin
        push_exp($sformatf("%s_byte%0d", tag, i), ref_byte(i));
        read_byte(i != nbytes - 1, d);
        obs_q.push_back(int'(d));
      end
      if (nbytes >= 6) m_dr = 1'b0;
    end
    bus_stop();
  endtask

  task automatic measure(input logic [15:0] t, input logic [15:0] rh, input string tag);
    Temp_Raw = t;
    RH_Raw   = rh;
    exp_cmd_q.push_back(32'hFD);
    i2c_write(8'h88, 8'hFD, 1'b1, tag);
    m_t  = t;
    m_rh = rh;
    m_dr = 1'b0;
    Temp_Raw = 16'($urandom);   // later input changes must not reach the frame
    RH_Raw   = 16'($urandom);
  endtask

  task automatic wait_ready(input string tag);
    int lat;
    for (int i = 0; i < MEAS + 100 && !Data_Ready; i++) @(negedge clk);
    lat = Data_Ready ? (cyc - strobe_cyc) : -1;
    sb_check({tag, "_meas_latency"}, lat, MEAS);
    m_dr = 1'b1;
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int oe0, len;
    logic ack, b;
    rst = 1'b1; scl_m = 1'b1; sda_m = 1'b1; Temp_Raw = 16'd0; RH_Raw = 16'd0;
`ifdef SHT40_CRC_INJECT_EN
    Crc_Inject = 1'b0;
`endif
    repeat (5) @(posedge clk);
    @(negedge clk);
    sb_check("rst_sda_oe",     int'(sda_oe),     0);
    sb_check("rst_cmd_strobe", int'(Cmd_Strobe), 0);
    sb_check("rst_cmd_byte",   int'(Cmd_Byte),   0);
    sb_check("rst_data_ready", int'(Data_Ready), 0);
    sb_check("rst_state",      int'(dut.state_q), int'(ST_IDLE));
    rst = 1'b0;
    repeat (5) @(negedge clk);

    // Measure 0xBEEF/0x6666, early read refused, then full frame.
    measure(16'hBEEF, 16'h6666, "beef");
    oe0 = oe_cnt;
    i2c_read(6, 1'b0, "early");
    sb_check("early_oe_quiet", oe_cnt - oe0, 0);
    sb_check("early_dr", int'(Data_Ready), 0);
    wait_ready("beef");
    sb_check("beef_crc_t_const", ref_byte(2), 8'h92);
    i2c_read(6, 1'b1, "beef");
    @(negedge clk);
    sb_check("beef_dr_after", int'(Data_Ready), int'(m_dr));

    // Wrong address.
    oe0 = oe_cnt;
    i2c_write(8'h8A, 8'hFD, 1'b0, "badaddr");
    repeat (5) @(negedge clk);
    sb_check("badaddr_oe_quiet", oe_cnt - oe0, 0);
    sb_check("badaddr_idle", int'(dut.state_q), int'(ST_IDLE));

    // Partial read keeps Data_Ready; unknown command has no effect; re-read full frame.
    measure(16'($urandom), 16'($urandom), "part");
    wait_ready("part");
    i2c_read(3, 1'b1, "part");
    @(negedge clk);
    sb_check("part_dr_kept", int'(Data_Ready), 1);
    exp_cmd_q.push_back(32'h12);
    i2c_write(8'h88, 8'h12, 1'b1, "other");
    @(negedge clk);
    sb_check("other_dr_kept", int'(Data_Ready), 1);
    i2c_read(7, 1'b1, "reread");
    @(negedge clk);
    sb_check("reread_dr", int'(Data_Ready), 0);

    // Soft reset aborts a running measurement.
    measure(16'($urandom), 16'($urandom), "sr");
    exp_cmd_q.push_back(32'h94);
    i2c_write(8'h88, 8'h94, 1'b1, "sr");
    repeat (MEAS + 50) @(negedge clk);
    sb_check("sr_dr", int'(Data_Ready), 0);
    m_dr = 1'b0;

    // Randomized measure/read rounds with random read lengths.
    for (int r = 0; r < 4; r++) begin
      measure(16'($urandom), 16'($urandom), $sformatf("rnd%0d", r));
      wait_ready($sformatf("rnd%0d", r));
      len = $urandom_range(1, 8);
      i2c_read(len, 1'b1, $sformatf("rnd%0d", r));
      @(negedge clk);
      sb_check($sformatf("rnd%0d_dr", r), int'(Data_Ready), int'(m_dr));
    end

    // Reset while the responder drives bit 3 of byte 0 (all-zero byte so SDA is held low).
    measure(16'h0000, 16'($urandom), "rstmid");
    wait_ready("rstmid");
    bus_start();
    write_byte(8'h89, ack);
    sb_check("rstmid_addr_ack", int'(ack), 1);
    for (int i = 0; i < 3; i++) read_bit(b);
    sda_m = 1'b1; #Q; scl_m = 1'b1; #Q;
    sb_check("rstmid_driving", int'(sda_oe), 1);
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1;
    sb_check("rstmid_oe_released", int'(sda_oe), 0);
    sb_check("rstmid_dr", int'(Data_Ready), 0);
    @(negedge clk);
    rst = 1'b0;
    m_dr = 1'b0;
    #Q; scl_m = 1'b0; #Q;
    bus_stop();
    measure(16'($urandom), 16'($urandom), "after_rst");
    wait_ready("after_rst");
    i2c_read(6, 1'b1, "after_rst");

`ifdef SHT40_CRC_INJECT_EN
    // Corrupted CRC bytes for a frame started with Crc_Inject high.
    measure(16'hBEEF, 16'h6666, "inj");
    wait_ready("inj");
    Crc_Inject = 1'b1;
    m_inj = 1'b1;
    sb_check("inj_crc_t_const", ref_byte(2), 8'h93);
    i2c_read(6, 1'b1, "inj");
    Crc_Inject = 1'b0;
    m_inj = 1'b0;
`endif

    repeat (20) @(negedge clk);
    n_total++;
    if (exp_q.size() == 0 && exp_cmd_q.size() == 0 && obs_q.size() == 0) n_pass++;
    else $display("FAIL drain: got %0d expectations and %0d strobes outstanding, expected 0 and 0",
                  exp_q.size(), exp_cmd_q.size());
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

  // Watchdog against a hung bus sequence.
  initial begin
    #900000;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $display("%0d/%0d checks passed", n_pass, n_total + 1);
    $fatal(1, "timeout");
  end

endmodule
